// File: rtl/joystick_conditioner.sv
// Pmod joystick front end: 2-FF sync, ticked debounce, active-high mapping,
// per-port fire autofire and a one-cycle output change strobe.
module joystick_conditioner #(
    parameter int unsigned tick_div       = 1000,
    parameter int unsigned debounce_ticks = 8,
    parameter int unsigned autofire_half  = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:4] pin_a,
    input  logic [0:4] pin_b,
    input  logic [0:1] autofire_en,
    output logic [0:4] joy1,
    output logic [0:4] joy2,
    output logic       changed,
    output logic       tick
);

    localparam int unsigned ports  = 2;
    localparam int unsigned bits   = 5;
    localparam int unsigned n      = ports * bits;
    localparam int unsigned tick_w = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam int unsigned deb_w  = (debounce_ticks > 1) ? $clog2(debounce_ticks) : 1;
    localparam int unsigned af_w   = (autofire_half > 1) ? $clog2(autofire_half) : 1;

    logic [0:n-1]        raw_c;
    logic [0:n-1]        sync1;
    logic [0:n-1]        sync2;
    logic [0:n-1]        stable;
    logic [deb_w-1:0]    deb_cnt [n];
    logic [tick_w-1:0]   tick_cnt;
    logic [af_w-1:0]     af_phase [ports];
    logic [0:ports-1]    af_level;
    logic [0:ports-1]    af_active_c;
    logic [0:n-1]        joy_c;

    assign raw_c = {pin_a, pin_b};

    // Two-stage synchroniser, idles at released (high)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
        end
    end

    // Sample-tick divider; tick is high while the count sits at tick_div-1
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            if (tick_cnt == tick_w'(tick_div - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + tick_w'(1);
            end
            tick <= (tick_cnt == tick_w'(tick_div - 2));
        end
    end

    // Per-bit debounce: a new level needs debounce_ticks consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '1;
            for (int i = 0; i < n; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < n; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == deb_w'(debounce_ticks - 1)) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + deb_w'(1);
                end
            end
        end
    end

    always_comb begin
        af_active_c = '0;
        for (int p = 0; p < ports; p++) begin
            af_active_c[p] = autofire_en[p] & ~stable[p * bits];
        end
    end

    // Autofire square wave; parked at phase 0 / level 1 whenever inactive
    always_ff @(posedge clk) begin
        if (reset) begin
            af_level <= '1;
            for (int p = 0; p < ports; p++) begin
                af_phase[p] <= '0;
            end
        end else begin
            for (int p = 0; p < ports; p++) begin
                if (!af_active_c[p]) begin
                    af_phase[p] <= '0;
                    af_level[p] <= 1'b1;
                end else if (tick) begin
                    if (af_phase[p] == af_w'(autofire_half - 1)) begin
                        af_phase[p] <= '0;
                        af_level[p] <= ~af_level[p];
                    end else begin
                        af_phase[p] <= af_phase[p] + af_w'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        joy_c = ~stable;
        for (int p = 0; p < ports; p++) begin
            if (af_active_c[p]) begin
                joy_c[p * bits] = af_level[p];
            end
        end
    end

    // Registered outputs; changed fires in the same cycle the new value appears
    always_ff @(posedge clk) begin
        if (reset) begin
            joy1    <= '0;
            joy2    <= '0;
            changed <= 1'b0;
        end else begin
            joy1    <= joy_c[0:4];
            joy2    <= joy_c[5:9];
            changed <= (joy_c != {joy1, joy2});
        end
    end

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with tick_div=10, debounce_ticks=4,
// autofire_half=3; expected values are hand-derived cycle counts from reset release.
module tb_joystick_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:4] pin_a;
    logic [0:4] pin_b;
    logic [0:1] autofire_en;
    logic [0:4] joy1;
    logic [0:4] joy2;
    logic       changed;
    logic       tick;

    int n_cmp  = 0;
    int n_err  = 0;
    int cy     = 0;
    int pulses = 0;

    joystick_conditioner #(
        .tick_div      (10),
        .debounce_ticks(4),
        .autofire_half (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pin_a      (pin_a),
        .pin_b      (pin_b),
        .autofire_en(autofire_en),
        .joy1       (joy1),
        .joy2       (joy2),
        .changed    (changed),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'b%0b expected 'b%0b", tag, obs, exp);
        end
    endtask

    // Advance to cycle q after the last reset release, counting changed pulses
    task automatic go_to(input int q);
        while (cy < q) begin
            @(posedge clk);
            #1;
            cy++;
            pulses += int'(changed);
        end
    endtask

    initial begin
        reset       = 1'b1;
        pin_a       = 5'b00000;
        pin_b       = 5'b00000;
        autofire_en = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_joy1", int'(joy1), 0);
        check("rst_joy2", int'(joy2), 0);
        check("rst_changed", int'(changed), 0);
        check("rst_tick", int'(tick), 0);

        // Power-up with everything held pressed
        reset  = 1'b0;
        cy     = 0;
        pulses = 0;
        go_to(8);   check("tick_c8", int'(tick), 0);
        go_to(9);   check("tick_c9", int'(tick), 1);
        go_to(10);  check("tick_c10", int'(tick), 0);
        go_to(19);  check("tick_c19", int'(tick), 1);
        go_to(40);  check("pwr_joy1_early", int'(joy1), 0);
                    check("pwr_no_pulse", pulses, 0);
        go_to(41);  check("pwr_joy1", int'(joy1), 'b11111);
                    check("pwr_joy2", int'(joy2), 'b11111);
                    check("pwr_changed", int'(changed), 1);
        go_to(42);  check("pwr_changed_end", int'(changed), 0);

        // Autofire on port 1 while up starts releasing, then reset mid-flight
        pin_a          = 5'b00001;
        autofire_en    = 2'b00;
        autofire_en[0] = 1'b1;
        go_to(43);  check("af_en_joy1", int'(joy1), 'b11111);
        go_to(70);  check("af_pre_toggle", int'(joy1), 'b11111);
        go_to(71);  check("af_toggle", int'(joy1), 'b01111);
                    check("af_toggle_chg", int'(changed), 1);
        reset = 1'b1;
        go_to(72);  check("mid_rst_joy1", int'(joy1), 0);
                    check("mid_rst_joy2", int'(joy2), 0);
                    check("mid_rst_changed", int'(changed), 0);
                    check("mid_rst_tick", int'(tick), 0);

        reset  = 1'b0;
        cy     = 0;
        pulses = 0;
        go_to(9);   check("re_tick_c9", int'(tick), 1);
        go_to(40);  check("re_joy1_early", int'(joy1), 0);
                    check("re_no_pulse", pulses, 0);
        go_to(41);  check("re_joy1", int'(joy1), 'b11110);
                    check("re_joy2", int'(joy2), 'b11111);
                    check("re_changed", int'(changed), 1);
        go_to(42);  check("re_changed_end", int'(changed), 0);
        go_to(70);  check("re_af_hold", int'(joy1), 'b11110);
        go_to(71);  check("re_af_low", int'(joy1), 'b01110);
                    check("re_af_joy2", int'(joy2), 'b11111);

        // Release fire: it lands while the autofire level is high
        pin_a = 5'b10001;
        go_to(101); check("rel_af_high", int'(joy1), 'b11110);
                    check("rel_af_chg", int'(changed), 1);
        go_to(110); check("rel_before", int'(joy1), 'b11110);
        go_to(111); check("rel_joy1", int'(joy1), 'b01110);
                    check("rel_changed", int'(changed), 1);

        // Re-press: autofire restarts at level 1 with a fresh phase
        pin_a = 5'b00001;
        go_to(150); check("rep_before", int'(joy1), 'b01110);
        go_to(151); check("rep_joy1", int'(joy1), 'b11110);
        go_to(180); check("rep_hold", int'(joy1), 'b11110);
        go_to(181); check("rep_toggle", int'(joy1), 'b01110);
                    check("rep_joy2", int'(joy2), 'b11111);

        // Drop autofire with fire held, then a glitchy press of up
        autofire_en = 2'b00;
        pin_a       = 5'b00000;
        go_to(182); check("af_off_joy1", int'(joy1), 'b11110);
                    check("af_off_chg", int'(changed), 1);
        pulses = 0;
        go_to(211);
        pin_a = 5'b00001;
        go_to(221);
        pin_a = 5'b00000;
        go_to(220 + 40);
                    check("glitch_joy1", int'(joy1), 'b11110);
                    check("glitch_no_pulse", pulses, 0);
        go_to(261); check("glitch_accept", int'(joy1), 'b11111);
                    check("glitch_chg", int'(changed), 1);

        // Simultaneous release then press on both ports
        pin_a  = 5'b00100;
        pin_b  = 5'b00010;
        go_to(262);
        pulses = 0;
        go_to(300); check("sim_rel_before", int'(joy1), 'b11111);
                    check("sim_rel_no_pulse", pulses, 0);
        go_to(301); check("sim_rel_joy1", int'(joy1), 'b11011);
                    check("sim_rel_joy2", int'(joy2), 'b11101);
                    check("sim_rel_chg", int'(changed), 1);
        go_to(302); check("sim_rel_chg_end", int'(changed), 0);
        pin_a  = 5'b00000;
        pin_b  = 5'b00000;
        pulses = 0;
        go_to(340); check("sim_fall_before", int'(joy2), 'b11101);
                    check("sim_fall_no_pulse", pulses, 0);
        go_to(341); check("sim_fall_joy1", int'(joy1), 'b11111);
                    check("sim_fall_joy2", int'(joy2), 'b11111);
                    check("sim_fall_chg", int'(changed), 1);
        go_to(342); check("sim_fall_chg_end", int'(changed), 0);
                    check("sim_fall_pulses", pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/joystick_conditioner.md
Name: joystick_conditioner

Overview:
Conditions the raw Pmod joystick pins before they reach the mainboard joy1/joy2 inputs. Each of the two ports has 5 active-low pins. The block synchronises them to clk, debounces each bit on a divided sample tick, inverts them to active-high, and can apply per-port autofire to the fire bit. It also emits a one-cycle change strobe that the service processor can use for input monitoring.

Parameters:
tick_div, 1000, clk cycles per debounce sample tick (must be ≥2)
debounce_ticks, 8, consecutive differing samples needed to accept a new level (must be ≥1)
autofire_half, 2048, sample ticks per autofire half-period (must be ≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
pin_a  input  [0:4]  port 1 raw pins, active-low, order {fire, left, right, down, up}
pin_b  input  [0:4]  port 2 raw pins, active-low, same order
autofire_en  input  [0:1]  bit 0 enables autofire on port 1, bit 1 on port 2
joy1  output  [0:4]  port 1 conditioned, active-high, same order as pin_a
joy2  output  [0:4]  port 2 conditioned, active-high
changed  output  1  one-cycle pulse when joy1 or joy2 differs from its previous-cycle value
tick  output  1  debounce sample strobe, exported for test

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset (applies whenever reset=1, including mid-debounce or mid-autofire):
  - both sync stages = all 1s (released); stable state = released; debounce counters = 0
  - tick divider = 0; autofire phase counters = 0; autofire level = 1
  - outputs: joy1 = 0, joy2 = 0, changed = 0, tick = 0
- Synchroniser: 2-FF per bit on all 10 pins; no logic between the two stages.
- Tick divider:
  - counts 0..tick_div-1 and wraps to 0
  - tick=1 for exactly the one cycle in which the count equals tick_div-1
- Debounce, per bit, on tick cycles only (state held between ticks):
  - synced sample == stable → counter := 0
  - else if counter == debounce_ticks-1 → stable := sample, counter := 0
  - else → counter := counter+1
  - Result: a change is accepted on the debounce_ticks-th consecutive differing tick. Any equal sample in between restarts the count (glitch rejection).
  - debounce_ticks=1: a change is accepted on the first differing tick.
- Output mapping:
  - joy bit = ~stable, registered, so 1 cycle after stable updates
  - latency from a clean pin edge = 2 sync cycles + tick alignment + (debounce_ticks-1) ticks + 1 cycle
- Autofire, per port, applies to bit 0 (fire) only:
  - Condition: autofire_en bit = 1 and the debounced fire is pressed.
  - Output fire = autofire level. The level starts at 1 on the first pressed cycle (no added latency).
  - Phase counter increments on each tick. On reaching autofire_half-1 it wraps to 0 and the level toggles.
  - When fire is released or autofire_en drops: phase := 0, level := 1, output fire = debounced fire.
  - autofire_en changing mid-press takes effect on the next cycle. Enabling autofire while fire is held starts with level 1 and phase 0.
  - Direction bits are never affected by autofire.
- changed: registered compare of {joy1, joy2} against the previous cycle; 1 for exactly one cycle per output change. Simultaneous changes on both ports produce a single pulse. Never asserted in the first cycle after reset release.
- Ports are independent: activity on pin_a never alters pin_b state or counters.

Test Plan:
- Reset hold with pins all 0 (pressed) → joy1=joy2=0, changed=0. After release with pins held 0, using tick_div=10, debounce_ticks=4: joy1=joy2=5'b11111 about 2+10*4+1 cycles later, with one changed pulse.
- Glitch rejection: pin_a[4] low for 3 ticks, high 1 tick, low 4 ticks (tick_div=10, debounce_ticks=4) → joy1[4] rises only after the final 4th consecutive tick; the 3-tick glitch gives no output change and no changed pulse.
- Autofire: autofire_en=2'b01, autofire_half=3, hold pin_a[0] low → joy1[0] goes 1 immediately on debounce acceptance, then toggles every 3 ticks. Release → joy1[0]=0 after debounce, with phase reset. pin_b[0] held low → joy2[0] steady 1.
- Mid-operation reset: assert reset during autofire and while a debounce counter is partially advanced → next cycle all outputs 0, counters 0. Behaviour after release matches the first scenario.
- Simultaneous: pin_a[2] and pin_b[3] fall in the same cycle → joy1[2] and joy2[3] rise in the same cycle, with exactly one changed pulse.
- Tick check: tick_div=10 → tick period exactly 10 cycles, first tick 9 cycles after reset release.
